// File: rtl/arb_pkg.sv
// Shared types, sizes and the round-robin pick function for the 4-requester arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 8;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic found;
        sel_t sel;
    } pick_t;

    // Search order starts just after the last winner and ends on it, so the last winner has lowest priority.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] valid, input sel_t last);
        pick_t r;
        sel_t  idx;
        r.found = 1'b0;
        r.sel   = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + sel_t'(k);
            if (!r.found && valid[idx]) begin
                r.found = 1'b1;
                r.sel   = idx;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb4_mux_if.sv
// Requester/consumer bus of rr_arb4_mux; io_grant_cnt exists only when ARB_GRANT_CNT_EN is defined.
interface rr_arb4_mux_if #(parameter int DATA_W = 2);
    import arb_pkg::*;

    logic [NUM_REQ-1:0] io_in_valid;
    logic [DATA_W-1:0]  io_in_data_0;
    logic [DATA_W-1:0]  io_in_data_1;
    logic [DATA_W-1:0]  io_in_data_2;
    logic [DATA_W-1:0]  io_in_data_3;
    logic [NUM_REQ-1:0] io_in_ready;
    logic               io_out_valid;
    logic               io_out_ready;
    logic [DATA_W-1:0]  io_out_data;
    sel_t               io_out_sel;
`ifdef ARB_GRANT_CNT_EN
    logic [NUM_REQ*CNT_W-1:0] io_grant_cnt;

    modport master (
        output io_in_valid, io_in_data_0, io_in_data_1, io_in_data_2, io_in_data_3, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_data, io_out_sel, io_grant_cnt
    );
    modport slave (
        input  io_in_valid, io_in_data_0, io_in_data_1, io_in_data_2, io_in_data_3, io_out_ready,
        output io_in_ready, io_out_valid, io_out_data, io_out_sel, io_grant_cnt
    );
`else
    modport master (
        output io_in_valid, io_in_data_0, io_in_data_1, io_in_data_2, io_in_data_3, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_data, io_out_sel
    );
    modport slave (
        input  io_in_valid, io_in_data_0, io_in_data_1, io_in_data_2, io_in_data_3, io_out_ready,
        output io_in_ready, io_out_valid, io_out_data, io_out_sel
    );
`endif

endinterface

// File: rtl/rr_arb4_mux_rr_pick4.sv
// Combinational round-robin rotation: picks the next valid requester after last.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  sel_t               last_i,
    output logic               found_o,
    output sel_t               winner_o
);

    pick_t pick_s;

    // Rotate priority around the previous winner.
    always_comb begin
        pick_s   = rr_pick(valid_i, last_i);
        found_o  = pick_s.found;
        winner_o = pick_s.sel;
    end

endmodule

// File: rtl/rr_arb4_mux.sv
// Round-robin 4-to-1 arbiter feeding a single registered output slot.
// Optional per-requester saturating grant counters under ARB_GRANT_CNT_EN.
module rr_arb4_mux
    import arb_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic          clock,
    input  logic          reset,
    rr_arb4_mux_if.slave  bus
);

    slot_state_t        state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    sel_t               sel_q, sel_d;
    sel_t               last_q, last_d;
    logic               found_s;
    sel_t               winner_s;
    logic               can_load_s;
    logic               load_s;
    logic [NUM_REQ-1:0] in_ready_s;
    logic [DATA_W-1:0]  mux_data_s;

    rr_pick4 u_pick (
        .valid_i  (bus.io_in_valid),
        .last_i   (last_q),
        .found_o  (found_s),
        .winner_o (winner_s)
    );

    // Input payload selector driven by the arbiter's winner.
    always_comb begin
        mux_data_s = '0;
        case (winner_s)
            2'd0:    mux_data_s = bus.io_in_data_0;
            2'd1:    mux_data_s = bus.io_in_data_1;
            2'd2:    mux_data_s = bus.io_in_data_2;
            default: mux_data_s = bus.io_in_data_3;
        endcase
    end

    // Slot next-state: a full slot being drained this cycle may be refilled in the same cycle.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sel_d      = sel_q;
        last_d     = last_q;
        can_load_s = (state_q == SLOT_EMPTY) || bus.io_out_ready;
        load_s     = can_load_s && found_s && !reset;
        in_ready_s = load_s ? (4'b0001 << winner_s) : 4'b0000;
        case (state_q)
            SLOT_EMPTY: begin
                if (load_s) state_d = SLOT_FULL;
                else        state_d = SLOT_EMPTY;
            end
            SLOT_FULL: begin
                if (load_s)                 state_d = SLOT_FULL;
                else if (bus.io_out_ready)  state_d = SLOT_EMPTY;
                else                        state_d = SLOT_FULL;
            end
            default: state_d = SLOT_EMPTY;
        endcase
        if (load_s) begin
            data_d = mux_data_s;
            sel_d  = winner_s;
            last_d = winner_s;
        end else begin
            data_d = data_q;
            sel_d  = sel_q;
            last_d = last_q;
        end
    end

    // Slot and priority-pointer registers; last resets to 3 so requester 0 wins first.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign bus.io_in_ready  = in_ready_s;
    assign bus.io_out_valid = (state_q == SLOT_FULL);
    assign bus.io_out_data  = data_q;
    assign bus.io_out_sel   = sel_q;

`ifdef ARB_GRANT_CNT_EN
    logic [CNT_W-1:0]         cnt_q [NUM_REQ];
    logic [CNT_W-1:0]         cnt_d [NUM_REQ];
    logic [NUM_REQ*CNT_W-1:0] cnt_flat_s;

    // Grant counters stick at 8'hFF rather than wrapping.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (load_s && (winner_s == sel_t'(i)) && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            cnt_flat_s[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.io_grant_cnt = cnt_flat_s;
`endif

endmodule

// File: tb/tb_rr_arb4_mux.sv
// Randomized + directed bench for rr_arb4_mux with a queue scoreboard and a behavioural model.
module tb_rr_arb4_mux;
    import arb_pkg::*;

    localparam int DW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    sel;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rr_arb4_mux_if #(.DATA_W(DW)) bus ();

    rr_arb4_mux #(.DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_last = 3;
    bit   m_full = 1'b0;
    int   m_cnt[4];

    // Drive one cycle of inputs, predict in_ready from the model, push expected slot contents.
    task automatic step(input logic [3:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                        input logic ordy, input logic rst);
        int            w;
        logic [3:0]    exp_rdy;
        logic [DW-1:0] dv[4];
        @(posedge clock);
        #2;
        reset            = rst;
        bus.io_in_valid  = v;
        bus.io_in_data_0 = d0;
        bus.io_in_data_1 = d1;
        bus.io_in_data_2 = d2;
        bus.io_in_data_3 = d3;
        bus.io_out_ready = ordy;
        @(negedge clock);
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        w = -1;
        if (!rst && (!m_full || ordy)) begin
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && v[(m_last + k) % 4]) w = (m_last + k) % 4;
            end
        end
        exp_rdy = (w >= 0) ? 4'(1 << w) : 4'b0000;
        total++;
        if (bus.io_in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL in_ready @%0t: got %b want %b", $time, bus.io_in_ready, exp_rdy);
        end
`ifdef ARB_GRANT_CNT_EN
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.io_grant_cnt[i*8 +: 8] !== 8'(m_cnt[i])) begin
                bad++;
                $display("FAIL grant_cnt[%0d] @%0t: got %0d want %0d", i, $time,
                         bus.io_grant_cnt[i*8 +: 8], m_cnt[i]);
            end
        end
`endif
        if (rst) begin
            exp_q.delete();
            m_full = 1'b0;
            m_last = 3;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (w >= 0) begin
            exp_q.push_back('{data: dv[w], sel: 2'(w)});
            m_full = 1'b1;
            m_last = w;
            if (m_cnt[w] < 255) m_cnt[w]++;
        end else if (ordy) begin
            m_full = 1'b0;
        end
    endtask

    // Monitor: retire the slot entry when the consumer takes it.
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.io_out_valid === 1'b1 && bus.io_out_ready === 1'b1
            && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    end

    // Monitor: compare the presented slot against the scoreboard head just after each edge.
    always @(posedge clock) begin
        #1;
        total++;
        if (bus.io_out_valid !== (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL out_valid @%0t: got %b want %b", $time, bus.io_out_valid, exp_q.size() != 0);
        end else if (bus.io_out_valid === 1'b1) begin
            total++;
            if (bus.io_out_data !== exp_q[0].data || bus.io_out_sel !== exp_q[0].sel) begin
                bad++;
                $display("FAIL out_slot @%0t: got data=%0d sel=%0d want data=%0d sel=%0d", $time,
                         bus.io_out_data, bus.io_out_sel, exp_q[0].data, exp_q[0].sel);
            end
        end
    end

    function automatic logic [DW-1:0] rd();
        return DW'($urandom);
    endfunction

    initial begin
        bus.io_in_valid  = 4'b0000;
        bus.io_in_data_0 = 2'd0;
        bus.io_in_data_1 = 2'd0;
        bus.io_in_data_2 = 2'd0;
        bus.io_in_data_3 = 2'd0;
        bus.io_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;

        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);

        // single request from requester 2
        step(4'b0100, 2'd0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);

        // all busy after reset: 0,1,2,3,0,1,2,3
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(4'b1111, rd(), rd(), rd(), rd(), 1'b1, 1'b0);

        // backpressure with everybody requesting
        for (int i = 0; i < 5; i++) step(4'b1111, rd(), rd(), rd(), rd(), 1'b0, 1'b0);
        step(4'b1111, rd(), rd(), rd(), rd(), 1'b1, 1'b0);
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);

        // skip and idle cycles
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1);
        step(4'b0010, 2'd0, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
        step(4'b0010, 2'd0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);

        // reset while the slot is full, then rotation restarts at 0
        step(4'b1111, rd(), rd(), rd(), rd(), 1'b0, 1'b0);
        step(4'b1111, rd(), rd(), rd(), rd(), 1'b1, 1'b1);
        step(4'b1111, rd(), rd(), rd(), rd(), 1'b1, 1'b0);
        step(4'b1111, rd(), rd(), rd(), rd(), 1'b1, 1'b0);

        // randomized traffic with sporadic resets
        for (int i = 0; i < 500; i++) begin
            step(4'($urandom), rd(), rd(), rd(), rd(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 63) == 0));
        end

`ifdef ARB_GRANT_CNT_EN
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(4'b1000, rd(), rd(), rd(), rd(), 1'b1, 1'b0);
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
`endif

        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
        @(posedge clock);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
